// File: rtl/oc8051_rom_arb_pkg.sv
// Shared types for the oc8051 program-ROM access controller: FSM state
// encoding, grant identifiers and the wait-counter width.
package oc8051_rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CAPT  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_MC = 1'b1
    } gnt_e;

    localparam int CNT_W = 4;

    function automatic gnt_e other_gnt(input gnt_e g);
        return (g == GNT_IF) ? GNT_MC : GNT_IF;
    endfunction

endpackage

// File: rtl/oc8051_rom_arb_pick.sv
// Requester eligibility and tie-break for the program-ROM arbiter.
// On a tie the grant goes to the requester that was not granted last.
module oc8051_rom_arb_pick
    import oc8051_rom_arb_pkg::*;
(
    input  logic if_req,
    input  logic if_ack,
    input  logic mc_req,
    input  logic mc_ack,
    input  gnt_e last_gnt,
    output logic gnt_valid,
    output gnt_e gnt_id
);

    // A port whose ack is showing this cycle already got its data; it is not
    // eligible again until the next cycle.
    logic if_elig;
    logic mc_elig;

    assign if_elig = if_req & ~if_ack;
    assign mc_elig = mc_req & ~mc_ack;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the ifs can leave it unassigned and infer a latch.
    always_comb begin
        gnt_valid = if_elig | mc_elig;
        gnt_id    = GNT_IF;
        if (if_elig && mc_elig) begin
            gnt_id = other_gnt(last_gnt);
        end else if (mc_elig) begin
            gnt_id = GNT_MC;
        end
    end

endmodule

// File: rtl/oc8051_rom_arb.sv
// Program-ROM access controller: shares the three-byte ROM port between fetch
// and MOVC. Define OC8051_ROM_ARB_RR_EN for round-robin tie-breaking.
module oc8051_rom_arb
    import oc8051_rom_arb_pkg::*;
#(
    parameter int INT_ROM_WID = 7,
    parameter int EXT_WAIT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [7:0]  if_data1,
    output logic [7:0]  if_data2,
    output logic [7:0]  if_data3,
    input  logic        mc_req,
    input  logic [15:0] mc_addr,
    output logic        mc_ack,
    output logic [7:0]  mc_data,
    output logic [15:0] rom_addr,
    input  logic        rom_ea_int,
    input  logic [7:0]  rom_data1,
    input  logic [7:0]  rom_data2,
    input  logic [7:0]  rom_data3,
    output logic        busy
);

    if (EXT_WAIT < 0 || EXT_WAIT > (1 << CNT_W) - 1) begin : g_bad_ext_wait
        $error("oc8051_rom_arb: EXT_WAIT must be within 0..15");
    end
    if (INT_ROM_WID < 1 || INT_ROM_WID > 16) begin : g_bad_rom_wid
        $error("oc8051_rom_arb: INT_ROM_WID must be within 1..16");
    end

    // WAIT counts down to zero inclusive, so it is loaded with one less.
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((EXT_WAIT > 0) ? EXT_WAIT - 1 : 0);

    state_e            state_q;
    state_e            state_d;
    gnt_e              gnt_q;
    logic [CNT_W-1:0]  cnt_q;
    gnt_e              last_gnt;
    logic              pick_valid;
    gnt_e              pick_id;

    oc8051_rom_arb_pick u_pick (
        .if_req    (if_req),
        .if_ack    (if_ack),
        .mc_req    (mc_req),
        .mc_ack    (mc_ack),
        .last_gnt  (last_gnt),
        .gnt_valid (pick_valid),
        .gnt_id    (pick_id)
    );

`ifdef OC8051_ROM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= GNT_MC;
        end else if (state_q == ST_IDLE && pick_valid) begin
            last_gnt <= pick_id;
        end
    end
`else
    // Pretending fetch always went last makes every tie go to MOVC.
    assign last_gnt = GNT_IF;
`endif

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (rom_ea_int || EXT_WAIT == 0) ? ST_CAPT : ST_WAIT;
            ST_WAIT:  if (cnt_q == '0) state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= GNT_IF;
            cnt_q    <= '0;
            rom_addr <= '0;
            if_ack   <= 1'b0;
            mc_ack   <= 1'b0;
            if_data1 <= '0;
            if_data2 <= '0;
            if_data3 <= '0;
            mc_data  <= '0;
        end else begin
            if_ack <= 1'b0;
            mc_ack <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Address is latched here; later requester changes are ignored.
                    if (pick_valid) begin
                        gnt_q    <= pick_id;
                        rom_addr <= (pick_id == GNT_MC) ? mc_addr : if_addr;
                    end
                end
                ST_ISSUE: cnt_q <= WAIT_INIT;
                ST_WAIT:  if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                ST_CAPT: begin
                    if (gnt_q == GNT_MC) begin
                        mc_data <= rom_data1;
                        mc_ack  <= 1'b1;
                    end else begin
                        if_data1 <= rom_data1;
                        if_data2 <= rom_data2;
                        if_data3 <= rom_data3;
                        if_ack   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_oc8051_rom_arb.sv
// Randomized bench for oc8051_rom_arb: a transaction-level schedule model
// predicts grant and ack cycles, a byte-array ROM predicts the data.
module tb_oc8051_rom_arb;

    localparam int EXT_WAIT = 2;
    localparam int INT_SIZE = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [7:0]  if_data1, if_data2, if_data3;
    logic        mc_req;
    logic [15:0] mc_addr;
    logic        mc_ack;
    logic [7:0]  mc_data;
    logic [15:0] rom_addr;
    logic        rom_ea_int;
    logic [7:0]  rom_data1, rom_data2, rom_data3;
    logic        busy;

    oc8051_rom_arb #(.INT_ROM_WID(7), .EXT_WAIT(EXT_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_data1   (if_data1),
        .if_data2   (if_data2),
        .if_data3   (if_data3),
        .mc_req     (mc_req),
        .mc_addr    (mc_addr),
        .mc_ack     (mc_ack),
        .mc_data    (mc_data),
        .rom_addr   (rom_addr),
        .rom_ea_int (rom_ea_int),
        .rom_data1  (rom_data1),
        .rom_data2  (rom_data2),
        .rom_data3  (rom_data3),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read ROM; the +1/+2 bytes wrap at 16'hFFFF.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        rom_data1 <= mem[rom_addr];
        rom_data2 <= mem[16'(rom_addr + 16'd1)];
        rom_data3 <= mem[16'(rom_addr + 16'd2)];
    end
    assign rom_ea_int = (rom_addr < 16'(INT_SIZE));

    typedef struct {
        logic        port;   // 0 fetch, 1 MOVC
        int          gnt;    // IDLE cycle in which the grant is taken
        int          ack;    // cycle in which the ack is visible
        logic [15:0] addr;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        cur_acc[$];
    int          checks = 0;
    int          failures = 0;
    logic [23:0] last_if;
    logic [7:0]  last_mc;
    logic        model_last;

    bit          ep_en[2];
    int          ep_off[2];
    int          ep_n[2];
    logic [15:0] ep_addr[2][2];
    bit          ep_drop[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] rom24(input logic [15:0] a);
        logic [15:0] a1;
        logic [15:0] a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        return {mem[a], mem[a1], mem[a2]};
    endfunction

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 16'($urandom_range(0, INT_SIZE - 1));
            2:       return 16'($urandom);
            default: return 16'(32'hFFFD + $urandom_range(0, 2));
        endcase
    endfunction

    task automatic set_req(input int p, input logic r, input logic [15:0] a);
        if (p == 0) begin
            if_req  = r;
            if_addr = a;
        end else begin
            mc_req  = r;
            mc_addr = a;
        end
    endtask

    // Called once per cycle at the falling edge, before inputs are changed.
    task automatic monitor();
        logic        ei, em, eb, chk;
        logic [15:0] ea;
        ei = exp_q.size() > 0 && exp_q[0].port == 1'b0 && exp_q[0].ack == cyc;
        em = exp_q.size() > 0 && exp_q[0].port == 1'b1 && exp_q[0].ack == cyc;
        check("if_ack", 32'(if_ack), 32'(ei));
        check("mc_ack", 32'(mc_ack), 32'(em));
        if (ei) begin
            last_if = rom24(exp_q[0].addr);
            void'(exp_q.pop_front());
        end
        if (em) begin
            last_mc = mem[exp_q[0].addr];
            void'(exp_q.pop_front());
        end
        check("if_data", 32'({if_data1, if_data2, if_data3}), 32'(last_if));
        check("mc_data", 32'(mc_data), 32'(last_mc));
        eb  = 1'b0;
        chk = 1'b0;
        ea  = '0;
        foreach (cur_acc[i]) begin
            if (cyc > cur_acc[i].gnt && cyc < cur_acc[i].ack) eb = 1'b1;
            if (cyc == cur_acc[i].gnt + 1) begin
                chk = 1'b1;
                ea  = cur_acc[i].addr;
            end
        end
        check("busy", 32'(busy), 32'(eb));
        if (chk) check("rom_addr", 32'(rom_addr), 32'(ea));
    endtask

    task automatic ep_clear();
        for (int i = 0; i < 2; i++) begin
            ep_en[i]   = 1'b0;
            ep_drop[i] = 1'b0;
            ep_n[i]    = 0;
            ep_off[i]  = 0;
        end
    endtask

    task automatic ep_port(input int p, input int off, input int n,
                           input logic [15:0] a0, input logic [15:0] a1, input bit drop);
        ep_en[p]      = 1'b1;
        ep_off[p]     = off;
        ep_n[p]       = n;
        ep_addr[p][0] = a0;
        ep_addr[p][1] = a1;
        ep_drop[p]    = drop && (n == 1);
    endtask

    // Entered at a falling edge with the arbiter idle; schedules the episode
    // from the arbitration rules, then drives it and compares every cycle.
    task automatic run_episode();
        int   start, free_at, last_ack, t, earliest, p;
        int   elig[2], qi[2], gnt_first[2], qd[2];
        bit   pend[2], started[2];
        logic ack_i;
        acc_t e;
        start    = cyc;
        free_at  = start;
        last_ack = start;
        cur_acc.delete();
        for (int i = 0; i < 2; i++) begin
            elig[i]      = start + ep_off[i];
            qi[i]        = 0;
            qd[i]        = 0;
            pend[i]      = ep_en[i];
            started[i]   = 1'b0;
            gnt_first[i] = -1;
        end
        while (pend[0] || pend[1]) begin
            earliest = 32'h7fff_ffff;
            for (int i = 0; i < 2; i++)
                if (pend[i] && elig[i] < earliest) earliest = elig[i];
            t = (earliest > free_at) ? earliest : free_at;
            if (pend[0] && pend[1] && elig[0] <= t && elig[1] <= t) begin
`ifdef OC8051_ROM_ARB_RR_EN
                p = (model_last == 1'b1) ? 0 : 1;
`else
                p = 1;
`endif
            end else if (pend[1] && elig[1] <= t) begin
                p = 1;
            end else begin
                p = 0;
            end
            e.port = 1'(p);
            e.gnt  = t;
            e.addr = ep_addr[p][qi[p]];
            e.ack  = t + 3 + ((e.addr >= 16'(INT_SIZE)) ? EXT_WAIT : 0);
            exp_q.push_back(e);
            cur_acc.push_back(e);
            if (gnt_first[p] < 0) gnt_first[p] = t;
            model_last = 1'(p);
            free_at    = e.ack;
            last_ack   = e.ack;
            qi[p]++;
            if (qi[p] < ep_n[p]) elig[p] = e.ack + 1;
            else pend[p] = 1'b0;
        end
        for (int c = start; c <= last_ack + 2; c++) begin
            monitor();
            for (int i = 0; i < 2; i++) begin
                ack_i = (i == 0) ? if_ack : mc_ack;
                if (ep_en[i] && !started[i] && c == start + ep_off[i]) begin
                    started[i] = 1'b1;
                    set_req(i, 1'b1, ep_addr[i][0]);
                end else if (started[i] && ack_i) begin
                    qd[i]++;
                    if (qd[i] < ep_n[i]) set_req(i, 1'b1, ep_addr[i][qd[i]]);
                    else set_req(i, 1'b0, 16'($urandom));
                end else if (ep_drop[i] && c == gnt_first[i] + 1) begin
                    // Drop the request and scramble the address mid-access.
                    set_req(i, 1'b0, 16'($urandom));
                end
            end
            @(negedge clk);
        end
        check("acks_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        mc_req = 1'b0;
        mc_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'h02;
        mem[16'h0001] = 8'h00;
        mem[16'h0002] = 8'h25;
        mem[16'h0003] = 8'h7F;
        mem[16'h0004] = 8'h2F;
        mem[16'h0005] = 8'h7E;
        mem[16'h0025] = 8'h78;
        last_if    = '0;
        last_mc    = '0;
        model_last = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_if_data", 32'({if_data1, if_data2, if_data3}), 32'd0);
        check("rst_mc_data", 32'(mc_data), 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_mc_ack", 32'(mc_ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        ep_clear(); ep_port(0, 0, 1, 16'h0003, 16'h0000, 1'b0); run_episode();
        ep_clear(); ep_port(1, 0, 1, 16'h0100, 16'h0000, 1'b0); run_episode();
        ep_clear(); ep_port(0, 0, 1, 16'h0000, 16'h0000, 1'b0);
                    ep_port(1, 0, 1, 16'h0025, 16'h0000, 1'b0); run_episode();
        ep_clear(); ep_port(0, 0, 2, 16'h0000, 16'h0003, 1'b0); run_episode();
        ep_clear(); ep_port(0, 1, 1, 16'hFFFE, 16'h0000, 1'b0); run_episode();
        ep_clear(); ep_port(1, 0, 1, 16'h0040, 16'h0000, 1'b1);
                    ep_port(0, 2, 1, 16'h8000, 16'h0000, 1'b0); run_episode();

        // Reset while an external MOVC access sits in WAIT.
        set_req(1, 1'b1, 16'h0200);
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        set_req(1, 1'b0, 16'h0000);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rom_addr", 32'(rom_addr), 32'd0);
        check("abort_if_data", 32'({if_data1, if_data2, if_data3}), 32'd0);
        check("abort_mc_data", 32'(mc_data), 32'd0);
        check("abort_mc_ack", 32'(mc_ack), 32'd0);
        rst = 1'b0;
        last_if    = '0;
        last_mc    = '0;
        model_last = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_mc_ack", 32'(mc_ack), 32'd0);
            check("abort_idle_busy", 32'(busy), 32'd0);
        end
        ep_clear(); ep_port(1, 0, 1, 16'h0005, 16'h0000, 1'b0); run_episode();

        for (int k = 0; k < 40; k++) begin
            ep_clear();
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) != 0)
                    ep_port(p, $urandom_range(0, 3), $urandom_range(1, 2),
                            rand_addr(), rand_addr(), $urandom_range(0, 3) == 0);
            end
            if (!ep_en[0] && !ep_en[1]) ep_port(0, 0, 1, rand_addr(), 16'h0000, 1'b0);
            run_episode();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
